// File: rtl/kinase_seq_pkg.sv
// Shared types, constants and pump phase pattern tables for the kinase valve sequencer.
package kinase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PUMP   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned N_PHASE = 6;
  localparam int unsigned PHASE_W = 3;

  // Bit positions within cmd_pump_sel
  localparam int unsigned SEL_A = 0;
  localparam int unsigned SEL_B = 1;

  // Three-valve peristaltic pattern for pump A
  function automatic logic [2:0] pump_a_pat(input logic [PHASE_W-1:0] ph);
    logic [2:0] pat;
    pat = 3'b000;
    case (ph)
      3'd0:    pat = 3'b100;
      3'd1:    pat = 3'b110;
      3'd2:    pat = 3'b010;
      3'd3:    pat = 3'b011;
      3'd4:    pat = 3'b001;
      3'd5:    pat = 3'b101;
      default: pat = 3'b000;
    endcase
    return pat;
  endfunction

  // Two-valve pattern for pump B
  function automatic logic [1:0] pump_b_pat(input logic [PHASE_W-1:0] ph);
    logic [1:0] pat;
    pat = 2'b00;
    case (ph)
      3'd0:    pat = 2'b10;
      3'd1:    pat = 2'b11;
      3'd2:    pat = 2'b01;
      3'd3:    pat = 2'b01;
      3'd4:    pat = 2'b11;
      3'd5:    pat = 2'b10;
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// Phase divider, six-phase counter and remaining-cycle counter for the pumps.
// phase reports the phase to present on the next clock; cycle_done flags the
// clock on which the final 5->0 wrap happens.
module pump_phase_gen
  import kinase_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned DIV_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [DIV_W-1:0]   div,
  input  logic [CNT_W-1:0]   cycles,
  output logic [PHASE_W-1:0] phase,
  output logic               cycle_done
);

  logic [DIV_W-1:0]   div_cnt;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   remaining;
  logic               active;
  logic               wrap;
  logic               last_phase;

  // Next-phase lookahead so the parent can register pad levels without lag
  always_comb begin
    wrap       = active && (div_cnt == div);
    last_phase = (phase_q == PHASE_W'(N_PHASE - 1));
    cycle_done = wrap && last_phase && (remaining == CNT_W'(1));
    phase      = phase_q;
    if (start) begin
      phase = '0;
    end else if (wrap) begin
      phase = last_phase ? '0 : phase_q + PHASE_W'(1);
    end
  end

  // Divider, phase and cycle counters; div is live so a change hits the next division
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      phase_q   <= '0;
      remaining <= '0;
      active    <= 1'b0;
    end else if (clear) begin
      div_cnt   <= '0;
      phase_q   <= '0;
      remaining <= '0;
      active    <= 1'b0;
    end else if (start) begin
      div_cnt   <= '0;
      phase_q   <= '0;
      remaining <= cycles;
      active    <= 1'b1;
    end else if (active) begin
      if (wrap) begin
        div_cnt <= '0;
        phase_q <= phase;
        if (last_phase) begin
          remaining <= remaining - CNT_W'(1);
        end
        if (cycle_done) begin
          active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Step sequencer driving the kinase_activity_pads control pads:
// valve pattern -> settle -> N peristaltic pump cycles -> done.
module kinase_valve_sequencer
  import kinase_seq_pkg::*;
#(
  parameter int unsigned N_CTRL_A      = 13,
  parameter int unsigned N_CTRL_S      = 4,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [N_CTRL_A-1:0] cmd_ctrl_a,
  input  logic [N_CTRL_S-1:0] cmd_ctrl_s,
  input  logic [1:0]          cmd_pump_sel,
  input  logic [CNT_W-1:0]    cmd_cycles,
  input  logic [DIV_W-1:0]    cfg_phase_div,
  input  logic                abort,
  output logic [N_CTRL_A-1:0] ctrl_a,
  output logic [N_CTRL_S-1:0] ctrl_s,
  output logic [2:0]          pump_a,
  output logic [1:0]          pump_b,
  output logic                busy,
  output logic                step_done,
  output logic                aborted
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [1:0]         sel_q;
  logic [CNT_W-1:0]   cycles_q;
  logic               accept;
  logic               run_pump;
  logic               pg_start;
  logic               pg_clear;
  logic [PHASE_W-1:0] pg_phase;
  logic               pg_done;
  logic [2:0]         pump_a_nxt;
  logic [1:0]         pump_b_nxt;

  // Handshake follows abort in the same cycle, so it is decoded from state rather than registered
  assign cmd_ready = (state == ST_IDLE) && !abort;

  // Step control decode and masked pad patterns for the next clock
  always_comb begin
    accept     = cmd_valid && cmd_ready;
    run_pump   = (sel_q != 2'b00) && (cycles_q != '0);
    pg_start   = (state == ST_SETTLE) && (settle_cnt == '0) && run_pump && !abort;
    pg_clear   = abort || (state == ST_IDLE);
    pump_a_nxt = sel_q[SEL_A] ? pump_a_pat(pg_phase) : 3'b000;
    pump_b_nxt = sel_q[SEL_B] ? pump_b_pat(pg_phase) : 2'b00;
  end

  pump_phase_gen #(
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
  ) u_phase_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (pg_start),
    .clear      (pg_clear),
    .div        (cfg_phase_div),
    .cycles     (cycles_q),
    .phase      (pg_phase),
    .cycle_done (pg_done)
  );

  // Sequencer FSM with registered pad and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      sel_q      <= '0;
      cycles_q   <= '0;
      ctrl_a     <= '0;
      ctrl_s     <= '0;
      pump_a     <= '0;
      pump_b     <= '0;
      busy       <= 1'b0;
      step_done  <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      step_done <= 1'b0;
      aborted   <= 1'b0;
      case (state)
        ST_IDLE: begin
          pump_a <= '0;
          pump_b <= '0;
          if (accept) begin
            ctrl_a     <= cmd_ctrl_a;
            ctrl_s     <= cmd_ctrl_s;
            sel_q      <= cmd_pump_sel;
            cycles_q   <= cmd_cycles;
            settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (settle_cnt == '0) begin
            if (run_pump) begin
              pump_a <= pump_a_nxt;
              pump_b <= pump_b_nxt;
              state  <= ST_PUMP;
            end else begin
              step_done <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        ST_PUMP: begin
          if (abort) begin
            pump_a  <= '0;
            pump_b  <= '0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (pg_done) begin
            pump_a    <= '0;
            pump_b    <= '0;
            step_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            pump_a <= pump_a_nxt;
            pump_b <= pump_b_nxt;
          end
        end
        ST_DONE: begin
          pump_a  <= '0;
          pump_b  <= '0;
          busy    <= 1'b0;
          aborted <= abort;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Self-checking bench for kinase_valve_sequencer: table of step commands with
// hand-computed pump durations, expected per-cycle pad levels queued as a
// scoreboard, plus abort and mid-step reset sequences.
module tb_kinase_valve_sequencer;

  localparam int unsigned S = 4;

  typedef struct packed {
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;
    logic        busy;
    logic        step_done;
    logic        aborted;
    logic        cmd_ready;
  } out_t;

  typedef struct {
    logic [12:0] a;
    logic [3:0]  s;
    logic [1:0]  sel;
    logic [11:0] cycles;
    logic [15:0] div;
    int          pump_clks;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_ctrl_a;
  logic [3:0]  cmd_ctrl_s;
  logic [1:0]  cmd_pump_sel;
  logic [11:0] cmd_cycles;
  logic [15:0] cfg_phase_div;
  logic        abort;
  logic [12:0] ctrl_a;
  logic [3:0]  ctrl_s;
  logic [2:0]  pump_a;
  logic [1:0]  pump_b;
  logic        busy;
  logic        step_done;
  logic        aborted;

  int   n_tests;
  int   n_fail;
  out_t exp_q[$];
  logic [2:0] pa_tab [6];
  logic [1:0] pb_tab [6];
  vec_t vecs [5];

  kinase_valve_sequencer #(
    .N_CTRL_A      (13),
    .N_CTRL_S      (4),
    .CNT_W         (12),
    .DIV_W         (16),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ctrl_a    (cmd_ctrl_a),
    .cmd_ctrl_s    (cmd_ctrl_s),
    .cmd_pump_sel  (cmd_pump_sel),
    .cmd_cycles    (cmd_cycles),
    .cfg_phase_div (cfg_phase_div),
    .abort         (abort),
    .ctrl_a        (ctrl_a),
    .ctrl_s        (ctrl_s),
    .pump_a        (pump_a),
    .pump_b        (pump_b),
    .busy          (busy),
    .step_done     (step_done),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input out_t exp);
    out_t got;
    got.ctrl_a    = ctrl_a;
    got.ctrl_s    = ctrl_s;
    got.pump_a    = pump_a;
    got.pump_b    = pump_b;
    got.busy      = busy;
    got.step_done = step_done;
    got.aborted   = aborted;
    got.cmd_ready = cmd_ready;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got a=%h s=%h pa=%b pb=%b busy=%b done=%b ab=%b rdy=%b, required a=%h s=%h pa=%b pb=%b busy=%b done=%b ab=%b rdy=%b",
               name, $time, got.ctrl_a, got.ctrl_s, got.pump_a, got.pump_b, got.busy,
               got.step_done, got.aborted, got.cmd_ready, exp.ctrl_a, exp.ctrl_s,
               exp.pump_a, exp.pump_b, exp.busy, exp.step_done, exp.aborted, exp.cmd_ready);
    end
  endtask

  function automatic out_t mk(input logic [12:0] a, input logic [3:0] s, input logic [2:0] pa,
                              input logic [1:0] pb, input logic bsy, input logic dn,
                              input logic ab, input logic rdy);
    out_t r;
    r.ctrl_a    = a;
    r.ctrl_s    = s;
    r.pump_a    = pa;
    r.pump_b    = pb;
    r.busy      = bsy;
    r.step_done = dn;
    r.aborted   = ab;
    r.cmd_ready = rdy;
    return r;
  endfunction

  // Expected settle cycles then the first n pump clocks of a step
  task automatic push_head(input vec_t v, input int n);
    int ph;
    logic [2:0] pa;
    logic [1:0] pb;
    for (int i = 0; i < int'(S); i++) exp_q.push_back(mk(v.a, v.s, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < n; k++) begin
      ph = (k / (int'(v.div) + 1)) % 6;
      pa = v.sel[0] ? pa_tab[ph] : 3'b000;
      pb = v.sel[1] ? pb_tab[ph] : 2'b00;
      exp_q.push_back(mk(v.a, v.s, pa, pb, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // Compare queued expectations, one per clock, sampled after the falling edge
  task automatic drain(input string name);
    out_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(name, e);
      @(negedge clk); #1;
    end
  endtask

  task automatic issue(input vec_t v);
    cmd_ctrl_a    = v.a;
    cmd_ctrl_s    = v.s;
    cmd_pump_sel  = v.sel;
    cmd_cycles    = v.cycles;
    cfg_phase_div = v.div;
    cmd_valid     = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  logic [12:0] cur_a;
  logic [3:0]  cur_s;
  vec_t        va;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_ctrl_a = '0;
    cmd_ctrl_s = '0;
    cmd_pump_sel = '0;
    cmd_cycles = '0;
    cfg_phase_div = '0;
    abort = 1'b0;
    pa_tab[0] = 3'b100; pa_tab[1] = 3'b110; pa_tab[2] = 3'b010;
    pa_tab[3] = 3'b011; pa_tab[4] = 3'b001; pa_tab[5] = 3'b101;
    pb_tab[0] = 2'b10;  pb_tab[1] = 2'b11;  pb_tab[2] = 2'b01;
    pb_tab[3] = 2'b01;  pb_tab[4] = 2'b11;  pb_tab[5] = 2'b10;
    // a, s, sel, cycles, div, hand-computed PUMP clocks
    vecs[0] = '{13'h1A5,  4'h9, 2'b01, 12'd2, 16'd0, 12};
    vecs[1] = '{13'h0F0,  4'h6, 2'b11, 12'd1, 16'd2, 18};
    vecs[2] = '{13'h1FFF, 4'hF, 2'b10, 12'd0, 16'd0, 0};
    vecs[3] = '{13'h0001, 4'h1, 2'b00, 12'd5, 16'd1, 0};
    vecs[4] = '{13'h0AAA, 4'h5, 2'b10, 12'd2, 16'd1, 24};

    #2 rst_n = 1'b0;
    #1 check("reset_async", mk(13'h0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_idle", mk(13'h0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); #1;
    cur_a = '0;
    cur_s = '0;

    // Table-driven steps
    for (int i = 0; i < 5; i++) begin
      check($sformatf("idle_before_v%0d", i), mk(cur_a, cur_s, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      issue(vecs[i]);
      push_head(vecs[i], vecs[i].pump_clks);
      exp_q.push_back(mk(vecs[i].a, vecs[i].s, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(vecs[i].a, vecs[i].s, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      drain($sformatf("step_v%0d", i));
      cur_a = vecs[i].a;
      cur_s = vecs[i].s;
    end
    check("held_after_steps", mk(cur_a, cur_s, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

    // Abort in the third PUMP phase, then valid+abort in IDLE must not be accepted
    va = '{13'h0123, 4'h3, 2'b01, 12'd3, 16'd1, 0};
    issue(va);
    push_head(va, 4);
    drain("abort_pre");
    check("abort_phase2", mk(13'h0123, 4'h3, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_ctrl_a = 13'h1FFF;
    cmd_ctrl_s = 4'hF;
    @(negedge clk); #1;
    check("abort_pulse", mk(13'h0123, 4'h3, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk); #1;
    check("abort_idle_block", mk(13'h0123, 4'h3, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1 check("abort_ready_back", mk(13'h0123, 4'h3, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); #1;
    check("abort_no_done", mk(13'h0123, 4'h3, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

    // Reset pulsed mid-PUMP clears everything asynchronously
    va = '{13'h0F0F, 4'hA, 2'b11, 12'd2, 16'd0, 0};
    issue(va);
    push_head(va, 3);
    drain("rst_pre");
    check("rst_pump_ph3", mk(13'h0F0F, 4'hA, 3'b011, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1 check("rst_mid_pump", mk(13'h0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_release_idle", mk(13'h0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
